// File: rtl/egress_scheduler_if.sv
// Queue-side and lane-side signals of one egress_scheduler instance.
interface egress_scheduler_if #(
    parameter int P_N_REQ = 4
);
    logic                   link_up_i;
    logic [P_N_REQ-1:0]     q_frame_avail_i;
    logic [P_N_REQ-1:0]     q_empty_i;
    logic [9*P_N_REQ-1:0]   q_data_i;
    logic [P_N_REQ-1:0]     q_rd_o;
    logic [7:0]             tx_data_o;
    logic                   tx_ctrl_o;
    logic [P_N_REQ-1:0]     grant_o;
    logic                   busy_o;
    logic                   err_underrun_o;
    logic                   err_oversize_o;
    logic [15:0]            frame_cnt_o;

    // Scheduler side: consumes queue heads, drives the transmit lane.
    modport master (
        input  link_up_i, q_frame_avail_i, q_empty_i, q_data_i,
        output q_rd_o, tx_data_o, tx_ctrl_o, grant_o, busy_o,
               err_underrun_o, err_oversize_o, frame_cnt_o
    );

    // Environment side: queues and PHY.
    modport slave (
        output link_up_i, q_frame_avail_i, q_empty_i, q_data_i,
        input  q_rd_o, tx_data_o, tx_ctrl_o, grant_o, busy_o,
               err_underrun_o, err_oversize_o, frame_cnt_o
    );
endinterface

// File: rtl/egress_scheduler.sv
// Frame-granular round-robin scheduler draining egress queues onto one TXD/TXC lane.
module egress_scheduler #(
    parameter int P_N_REQ     = 4,
    parameter int P_IFG       = 12,
    parameter int P_MAX_LEN   = 1522,
    parameter int P_LEN_WIDTH = 11
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    egress_scheduler_if.master bus
);
    localparam int unsigned IDX_W = (P_N_REQ > 1) ? $clog2(P_N_REQ) : 1;
    localparam int unsigned GAP_W = (P_IFG > 1) ? $clog2(P_IFG) : 1;
    localparam int unsigned LEN_W = P_LEN_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]         state, d_state;
    logic [IDX_W-1:0]   ptr, d_ptr;
    logic [LEN_W-1:0]   cnt, d_cnt;
    logic [GAP_W-1:0]   gcnt, d_gcnt;
    logic               bad, d_bad;
    logic [P_N_REQ-1:0] grant, d_grant;
    logic [7:0]         tx_data, d_tx_data;
    logic               tx_ctrl, d_tx_ctrl;
    logic               busy, d_busy;
    logic               err_u, d_err_u;
    logic               err_o, d_err_o;
    logic [15:0]        fcnt, d_fcnt;
    logic [P_N_REQ-1:0] q_rd_c;

    logic [8:0]         head [P_N_REQ];
    logic [P_N_REQ-1:0] req;
    logic               found;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   cand;
    logic [7:0]         pop_byte;
    logic               pop_last;
    logic               owner_empty;

    // Next-state, pop strobe and next values of all registered outputs.
    always_comb begin
        d_state     = state;
        d_ptr       = ptr;
        d_cnt       = cnt;
        d_gcnt      = gcnt;
        d_bad       = bad;
        d_grant     = grant;
        d_tx_data   = tx_data;
        d_tx_ctrl   = 1'b0;
        d_err_u     = 1'b0;
        d_err_o     = 1'b0;
        d_fcnt      = fcnt;
        q_rd_c      = '0;
        found       = 1'b0;
        sel         = ptr;
        cand        = '0;
        for (int i = 0; i < P_N_REQ; i++) begin
            head[i] = bus.q_data_i[9*i +: 9];
        end
        req         = bus.q_frame_avail_i & {P_N_REQ{bus.link_up_i}};
        pop_byte    = head[ptr][7:0];
        pop_last    = head[ptr][8];
        owner_empty = bus.q_empty_i[ptr];

        case (state)
            S_IDLE: begin
                // Cyclic search starting just after the last owner.
                for (int i = 1; i <= P_N_REQ; i++) begin
                    cand = IDX_W'((int'(ptr) + i) % P_N_REQ);
                    if (!found && req[cand]) begin
                        found = 1'b1;
                        sel   = cand;
                    end
                end
                if (found) begin
                    d_state       = S_SEND;
                    d_ptr         = sel;
                    d_grant       = '0;
                    d_grant[sel]  = 1'b1;
                    d_cnt         = '0;
                    d_bad         = 1'b0;
                end
            end
            S_SEND: begin
                if (owner_empty) begin
                    d_err_u = 1'b1;
                end else begin
                    q_rd_c = grant;
                    if (cnt != '1) begin
                        d_cnt = cnt + 1'b1;
                    end
                    // Bytes past the length limit or during link loss are drained silently.
                    if (cnt < LEN_W'(P_MAX_LEN) && bus.link_up_i) begin
                        d_tx_ctrl = 1'b1;
                        d_tx_data = pop_byte;
                    end else begin
                        d_bad = 1'b1;
                    end
                    if (cnt == LEN_W'(P_MAX_LEN) && !pop_last) begin
                        d_err_o = 1'b1;
                    end
                    if (pop_last) begin
                        d_state = S_GAP;
                        d_grant = '0;
                        d_gcnt  = '0;
                        if (!d_bad && fcnt != 16'hFFFF) begin
                            d_fcnt = fcnt + 16'd1;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gcnt == GAP_W'(P_IFG - 1)) begin
                    d_state = S_IDLE;
                end else begin
                    d_gcnt = gcnt + 1'b1;
                end
            end
            default: begin
                d_state = S_IDLE;
            end
        endcase

        d_busy = (d_state != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= S_IDLE;
            ptr     <= IDX_W'(P_N_REQ - 1);
            cnt     <= '0;
            gcnt    <= '0;
            bad     <= 1'b0;
            grant   <= '0;
            tx_data <= '0;
            tx_ctrl <= 1'b0;
            busy    <= 1'b0;
            err_u   <= 1'b0;
            err_o   <= 1'b0;
            fcnt    <= '0;
        end else begin
            state   <= d_state;
            ptr     <= d_ptr;
            cnt     <= d_cnt;
            gcnt    <= d_gcnt;
            bad     <= d_bad;
            grant   <= d_grant;
            tx_data <= d_tx_data;
            tx_ctrl <= d_tx_ctrl;
            busy    <= d_busy;
            err_u   <= d_err_u;
            err_o   <= d_err_o;
            fcnt    <= d_fcnt;
        end
    end

    assign bus.q_rd_o         = q_rd_c;
    assign bus.tx_data_o      = tx_data;
    assign bus.tx_ctrl_o      = tx_ctrl;
    assign bus.grant_o        = grant;
    assign bus.busy_o         = busy;
    assign bus.err_underrun_o = err_u;
    assign bus.err_oversize_o = err_o;
    assign bus.frame_cnt_o    = fcnt;
endmodule

// File: tb/tb_egress_scheduler.sv
// Scoreboard bench for egress_scheduler: queue models feed the DUT, a monitor checks the lane.
module tb_egress_scheduler;
    logic clk;
    logic rstn;

    egress_scheduler_if #(.P_N_REQ(4)) bus ();

    egress_scheduler #(
        .P_N_REQ(4), .P_IFG(12), .P_MAX_LEN(1522), .P_LEN_WIDTH(11)
    ) dut (
        .clk_i (clk),
        .rstn_i(rstn),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0]  exp_q [$];
    logic [8:0]  mem [4][4096];
    logic [11:0] rd [4] = '{default: '0};
    logic [11:0] wr [4] = '{default: '0};
    int          pushed [4] = '{default: 0};
    int          popped [4] = '{default: 0};
    logic [3:0]  force_empty = '0;
    logic [3:0]  flush = '0;

    int          n_hi, n_under, n_over, n_grants, n_gaps;
    logic [3:0]  glog [16];
    int          gaps [16];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // First-word-fall-through heads of the four queue models.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bus.q_data_i[9*i +: 9] = mem[i][rd[i]];
            bus.q_empty_i[i]       = (rd[i] == wr[i]) || force_empty[i];
            bus.q_frame_avail_i[i] = (pushed[i] > popped[i]);
        end
    end

    // Queue read pointers follow the DUT pops; flush drops a partial frame.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (flush[i]) begin
                rd[i]     <= wr[i];
                popped[i] <= pushed[i];
            end else if (bus.q_rd_o[i]) begin
                rd[i] <= rd[i] + 12'd1;
                if (mem[i][rd[i]][8]) popped[i] <= popped[i] + 1;
            end
        end
    end

    // Lane monitor: every transmitted byte must match the scoreboard head.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rstn && bus.tx_ctrl_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL tx_unexpected: got byte %02h, required no byte", bus.tx_data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.tx_data_o !== e) begin
                        failures++;
                        $display("FAIL tx_byte: got %02h required %02h", bus.tx_data_o, e);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Load a frame into queue q; the first ntx bytes are expected on the lane.
    task automatic push_frame(input int q, input int len, input int base, input int ntx);
        logic [7:0] b;
        for (int j = 0; j < len; j++) begin
            b = 8'((base + j) & 255);
            mem[q][wr[q] + 12'(j)] = {(j == len - 1), b};
            if (j < ntx) exp_q.push_back(b);
        end
        wr[q] = wr[q] + 12'(len);
        pushed[q]++;
    endtask

    // Run until the scheduler has been idle 4 cycles, gathering lane statistics.
    task automatic run(input int budget, input int under_at, input int drop_at, input int rst_at);
        int quiet, cyc, low_run, fe_left;
        bit seen_hi, fired_u, fired_d;
        logic [3:0] prev_grant;
        quiet = 0; cyc = 0; low_run = 0; fe_left = 0;
        seen_hi = 0; fired_u = 0; fired_d = 0; prev_grant = '0;
        n_hi = 0; n_under = 0; n_over = 0; n_grants = 0; n_gaps = 0;
        while (quiet < 4) begin
            @(negedge clk);
            cyc++;
            if (cyc > budget) begin
                checks++;
                failures++;
                $display("FAIL run_timeout: got %0d cycles, required at most %0d", cyc, budget);
                return;
            end
            if (bus.tx_ctrl_o) begin
                if (seen_hi && low_run > 0) begin
                    if (n_gaps < 16) gaps[n_gaps] = low_run;
                    n_gaps++;
                end
                n_hi++;
                seen_hi = 1;
                low_run = 0;
            end else begin
                low_run++;
            end
            if (bus.err_underrun_o) n_under++;
            if (bus.err_oversize_o) n_over++;
            if (bus.grant_o != 4'd0 && prev_grant == 4'd0) begin
                if (n_grants < 16) glog[n_grants] = bus.grant_o;
                n_grants++;
            end
            prev_grant = bus.grant_o;
            quiet = bus.busy_o ? 0 : quiet + 1;
            if (fe_left > 0) begin
                chk("underrun_stall", {bus.tx_ctrl_o, bus.err_underrun_o, bus.q_rd_o}, {1'b0, 1'b1, 4'b0000});
                fe_left--;
                if (fe_left == 0) force_empty = '0;
            end
            if (!fired_u && under_at > 0 && n_hi == under_at) begin
                force_empty = 4'hF;
                fe_left = 3;
                fired_u = 1;
            end
            if (!fired_d && drop_at > 0 && n_hi == drop_at) begin
                bus.link_up_i = 1'b0;
                fired_d = 1;
            end
            if (rst_at > 0 && n_hi == rst_at) begin
                #2 rstn = 1'b0;
                #1;
                chk("rst_async_grant", bus.grant_o, 4'b0000);
                chk("rst_async_tx", {bus.tx_ctrl_o, bus.tx_data_o}, 9'h000);
                chk("rst_async_busy_err", {bus.busy_o, bus.err_underrun_o, bus.err_oversize_o}, 3'b000);
                chk("rst_async_cnt_rd", {bus.frame_cnt_o, bus.q_rd_o}, 20'h0);
                return;
            end
        end
    endtask

    initial begin
        bit seen;
        rstn = 1'b0;
        bus.link_up_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_grant", bus.grant_o, 4'b0000);
        chk("reset_tx_ctrl", bus.tx_ctrl_o, 1'b0);
        chk("reset_busy_cnt", {bus.busy_o, bus.frame_cnt_o}, 17'h0);
        rstn = 1'b1;
        @(negedge clk);

        // Round robin: two 60-byte frames in every queue.
        for (int f = 0; f < 2; f++)
            for (int q = 0; q < 4; q++)
                push_frame(q, 60, 16 * (4 * f + q), 60);
        run(3000, 0, 0, 0);
        for (int k = 0; k < 8; k++)
            chk($sformatf("rr_grant_%0d", k), glog[k], 4'b0001 << (k % 4));
        chk("rr_gap_count", n_gaps, 7);
        for (int k = 0; k < 7; k++)
            chk($sformatf("rr_gap_len_%0d", k), gaps[k], 13);
        chk("rr_frame_cnt", bus.frame_cnt_o, 16'd8);

        // Single 64-byte frame from queue 2.
        push_frame(2, 64, 8'h30, 64);
        @(negedge clk);
        chk("single_grant", bus.grant_o, 4'b0100);
        chk("single_first_tx_latency", bus.tx_ctrl_o, 1'b0);
        run(500, 0, 0, 0);
        chk("single_tx_bytes", n_hi, 64);
        chk("single_contiguous", n_gaps, 0);
        chk("single_frame_cnt", bus.frame_cnt_o, 16'd9);

        // Oversize 1600-byte frame, truncated at 1522.
        push_frame(1, 1600, 8'h11, 1522);
        run(3000, 0, 0, 0);
        chk("over_tx_bytes", n_hi, 1522);
        chk("over_pulses", n_over, 1);
        chk("over_all_popped", rd[1], wr[1]);
        chk("over_frame_cnt", bus.frame_cnt_o, 16'd9);

        // Underrun: queue 3 runs dry for 3 cycles after byte 10.
        push_frame(3, 20, 8'hA0, 20);
        run(500, 10, 0, 0);
        chk("under_pulses", n_under, 3);
        chk("under_tx_bytes", n_hi, 20);
        chk("under_frame_cnt", bus.frame_cnt_o, 16'd10);

        // Link drop from byte 20 of a 100-byte frame.
        push_frame(0, 100, 8'h55, 19);
        run(500, 0, 19, 0);
        chk("drop_tx_bytes", n_hi, 19);
        chk("drop_all_popped", rd[0], wr[0]);
        chk("drop_frame_cnt", bus.frame_cnt_o, 16'd10);
        push_frame(1, 30, 8'hC0, 30);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.grant_o != 4'd0 || bus.busy_o) seen = 1;
        end
        chk("drop_no_grant", seen, 1'b0);
        bus.link_up_i = 1'b1;
        run(500, 0, 0, 0);
        chk("relink_tx_bytes", n_hi, 30);
        chk("relink_frame_cnt", bus.frame_cnt_o, 16'd11);

        // Asynchronous reset at byte 30 of a 50-byte frame.
        push_frame(2, 50, 8'h70, 50);
        run(500, 0, 0, 30);
        exp_q.delete();
        flush = 4'b0100;
        @(negedge clk);
        flush = 4'b0000;
        @(negedge clk);
        rstn = 1'b1;
        push_frame(3, 10, 8'hE0, 0);
        push_frame(0, 10, 8'h90, 10);
        for (int j = 0; j < 10; j++) exp_q.push_back(8'(8'hE0 + j));
        @(negedge clk);
        chk("post_rst_grant", bus.grant_o, 4'b0001);
        run(500, 0, 0, 0);
        chk("post_rst_second_grant", glog[1], 4'b1000);
        chk("post_rst_tx_bytes", n_hi, 20);
        chk("post_rst_frame_cnt", bus.frame_cnt_o, 16'd2);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/egress_scheduler.md
# egress_scheduler

Per-output-port frame scheduler between the switch's egress queues and one transmit lane. It arbitrates round-robin among P_N_REQ input queues at frame granularity and drains the granted queue byte by byte onto the TXD/TXC lane. It enforces the inter-frame gap and truncates oversize frames. One instance drives each of the four output ports.

## Interface
- P_N_REQ, 4, number of requesting queues (one per ingress port)
- P_IFG, 12, idle cycles guaranteed between frames (min 1)
- P_MAX_LEN, 1522, max bytes forwarded per frame; longer frames truncated
- P_LEN_WIDTH, 11, byte-counter width; must satisfy 2^P_LEN_WIDTH > P_MAX_LEN
- clk_i  in  1  single clock for the whole block
- rstn_i  in  1  reset, asynchronous, active-low
- link_up_i  in  1  peer present on this port's physical lane
- q_frame_avail_i  in  P_N_REQ  queue i holds at least one complete frame
- q_empty_i  in  P_N_REQ  queue i empty
- q_data_i  in  9*P_N_REQ  first-word-fall-through head of queue i at bits [9i+8:9i] = {last, byte}
- q_rd_o  out  P_N_REQ  one-hot pop; combinational from state, grant_o and q_empty_i
- tx_data_o  out  8  transmit byte (TXD), registered
- tx_ctrl_o  out  1  transmit valid (TXC), registered
- grant_o  out  P_N_REQ  registered one-hot current owner, 0 when idle
- busy_o  out  1  high in SEND or GAP
- err_underrun_o  out  1  one-cycle pulse per starved SEND cycle
- err_oversize_o  out  1  one-cycle pulse when truncation starts
- frame_cnt_o  out  16  frames fully sent, saturating at 0xFFFF

## Operation
- States: IDLE, SEND, GAP. Reset enters IDLE.
- Reset values: tx_data_o=0, tx_ctrl_o=0, q_rd_o=0, grant_o=0, busy_o=0, err_*=0, frame_cnt_o=0, byte counter=0, RR pointer=P_N_REQ-1. With the pointer at P_N_REQ-1, queue 0 has first priority.
- IDLE: a request is q_frame_avail_i gated by link_up_i. If any request exists, select the first requesting index searching cyclically from pointer+1. Load that index into grant_o and the pointer, clear the byte counter, go to SEND. With no request, stay in IDLE.
- SEND: when the owner is not empty, q_rd_o[owner]=1 and the byte counter increments, saturating.
  - tx_data_o<=byte; tx_ctrl_o<=1 only if the counter before increment is < P_MAX_LEN and link_up_i=1. Otherwise tx_ctrl_o<=0 and the byte is discarded.
  - err_oversize_o pulses in the cycle the counter equals P_MAX_LEN and the popped byte is not last.
  - If the owner is empty: q_rd_o=0, tx_ctrl_o<=0, err_underrun_o=1, stay in SEND.
  - Popping a byte with last=1 goes to GAP and clears grant_o. frame_cnt_o increments only if the frame was neither truncated nor hit link loss.
- GAP: tx_ctrl_o<=0; counts P_IFG cycles, then returns to IDLE.
- Link loss mid-frame: the scheduler keeps draining to the last byte with tx_ctrl_o low. It never leaves a partial frame in a queue.
- tx_data_o holds its last value whenever tx_ctrl_o=0.

## Timing
- Request seen in IDLE at cycle t: grant_o valid at t+1, first pop at t+1, first byte on tx at t+2.
- Throughput: one byte per cycle while the owner is non-empty.
- Last byte popped at cycle k: on tx at k+1. GAP covers k+1..k+P_IFG, IDLE at k+P_IFG+1.
- Back-to-back frames: tx_ctrl_o low for exactly P_IFG+1 cycles.
- A request arriving during SEND or GAP is not considered until IDLE. The owner is never preempted.
- Asynchronous reset mid-frame: all outputs return to reset values immediately. The partial frame remains in the queue and is the queue owner's responsibility.

## Test plan
- Single frame: queue 2 only, 64-byte frame, last on byte 64.
  - grant_o=4'b0100 one cycle after request.
  - tx_ctrl_o high for exactly 64 contiguous cycles with bytes in order.
  - frame_cnt_o=1.
- Round-robin fairness: all four queues hold two 60-byte frames each.
  - Grant order is 0,1,2,3,0,1,2,3.
  - Each gap has exactly 13 low tx_ctrl_o cycles (P_IFG=12).
- Oversize: 1600-byte frame with P_MAX_LEN=1522.
  - 1522 bytes transmitted; err_oversize_o pulses once.
  - 78 bytes popped with tx_ctrl_o=0; frame_cnt_o unchanged.
- Underrun: owner q_empty_i forced high for 3 cycles at byte 10.
  - q_rd_o=0 and tx_ctrl_o=0 for 3 cycles; err_underrun_o high for 3 cycles.
  - Transmission resumes with byte 11.
- Link drop at byte 20 of 100: tx_ctrl_o low from byte 20 onward.
  - All 100 bytes are popped.
  - No grant while link_up_i=0, even with q_frame_avail_i set.
- Reset mid-frame at byte 30 (asynchronous).
  - All outputs are 0 in the same cycle.
  - After release, the pointer restarts so queue 0 wins over queue 3 when both request.
